// File: rtl/vend_ctrl_multi.sv
// Multi-slot vending controller: per-item stock/sold/price, coin payment,
// coin-by-coin change over valid/ready, and admin restock/price programming.
module vend_ctrl_multi #(
   parameter int N_ITEMS   = 8,
   parameter int ID_W      = 3,
   parameter int STOCK_W   = 4,
   parameter int MAX_STOCK = 15,
   parameter int MONEY_W   = 7,
   parameter int SALE_W    = 10,
   parameter int DEF_PRICE = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sel_plus,
   input  logic               sel_minus,
   input  logic               confirm,
   input  logic               cancel,
   input  logic               coin_valid,
   input  logic [3:0]         coin_val,
   input  logic               adm_mode,
   input  logic               adm_restock,
   input  logic               adm_price_wr,
   input  logic [MONEY_W-1:0] adm_price,
   input  logic               chg_ready,
   output logic               chg_valid,
   output logic [3:0]         chg_coin,
   output logic [2:0]         state,
   output logic [ID_W-1:0]    cur_id,
   output logic [STOCK_W-1:0] cur_stock,
   output logic [STOCK_W-1:0] cur_sold,
   output logic [MONEY_W-1:0] cur_price,
   output logic [MONEY_W-1:0] paid,
   output logic [MONEY_W-1:0] change_left,
   output logic [SALE_W-1:0]  sale_total,
   output logic               sold_out,
   output logic               vend_pulse,
   output logic               coin_reject
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PAY    = 3'd1,
      S_VEND   = 3'd2,
      S_CHANGE = 3'd3,
      S_ADMIN  = 3'd4
   } st_t;

   localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(N_ITEMS - 1);
   localparam logic [STOCK_W-1:0] STOCK_TOP = '1;

   st_t st, st_nxt;

   logic [STOCK_W-1:0] stock [N_ITEMS];
   logic [STOCK_W-1:0] sold  [N_ITEMS];
   logic [MONEY_W-1:0] price [N_ITEMS];

   logic [ID_W-1:0]    id_r, id_nxt, id_inc, id_dec, sel_id;
   logic [MONEY_W-1:0] paid_r, paid_nxt, chg_r, chg_nxt, paid_after;
   logic [SALE_W-1:0]  sale_r, sale_nxt;
   logic               vend_r, vend_nxt, rej_r, rej_nxt;
   logic               do_vend, do_restock, do_price;
   logic               coin_legal, coin_ok;
   logic [MONEY_W:0]   coin_sum;
   logic [SALE_W:0]    sale_sum;
   logic [STOCK_W-1:0] sold_inc;

   assign state       = st;
   assign cur_id      = id_r;
   assign cur_stock   = stock[id_r];
   assign cur_sold    = sold[id_r];
   assign cur_price   = price[id_r];
   assign paid        = paid_r;
   assign change_left = chg_r;
   assign sale_total  = sale_r;
   assign vend_pulse  = vend_r;
   assign coin_reject = rej_r;
   assign sold_out    = (cur_stock == '0);
   assign chg_valid   = (st == S_CHANGE);

   assign id_inc = (id_r == LAST_ID) ? '0 : id_r + 1'b1;
   assign id_dec = (id_r == '0) ? LAST_ID : id_r - 1'b1;
   assign sel_id = (sel_plus && !sel_minus) ? id_inc :
                   (sel_minus && !sel_plus) ? id_dec : id_r;

   // A coin that would overflow the paid register is refused, not clipped
   assign coin_legal = (coin_val == 4'd1) || (coin_val == 4'd2) ||
                       (coin_val == 4'd5) || (coin_val == 4'd10);
   assign coin_sum   = {1'b0, paid_r} + (MONEY_W+1)'(coin_val);
   assign coin_ok    = coin_valid && coin_legal && !coin_sum[MONEY_W];
   assign paid_after = coin_ok ? coin_sum[MONEY_W-1:0] : paid_r;

   assign sale_sum = {1'b0, sale_r} + (SALE_W+1)'(cur_price);
   assign sold_inc = (cur_sold == STOCK_TOP) ? cur_sold : cur_sold + 1'b1;

   always_comb begin
      chg_coin = 4'd0;
      if (chg_r >= MONEY_W'(10))
         chg_coin = 4'd10;
      else if (chg_r >= MONEY_W'(5))
         chg_coin = 4'd5;
      else if (chg_r >= MONEY_W'(2))
         chg_coin = 4'd2;
      else if (chg_r >= MONEY_W'(1))
         chg_coin = 4'd1;
   end

   always_comb begin
      st_nxt     = st;
      id_nxt     = id_r;
      paid_nxt   = paid_r;
      chg_nxt    = chg_r;
      sale_nxt   = sale_r;
      vend_nxt   = 1'b0;
      rej_nxt    = 1'b0;
      do_vend    = 1'b0;
      do_restock = 1'b0;
      do_price   = 1'b0;
      unique case (st)
         S_IDLE: begin
            rej_nxt = coin_valid;
            if (adm_mode) begin
               st_nxt = S_ADMIN;
               id_nxt = sel_id;
            end else if (confirm && !sold_out) begin
               st_nxt   = S_PAY;
               paid_nxt = '0;
            end else begin
               id_nxt = sel_id;
            end
         end
         S_PAY: begin
            rej_nxt  = coin_valid && !coin_ok;
            paid_nxt = paid_after;
            if (cancel) begin
               chg_nxt  = paid_after;
               paid_nxt = '0;
               st_nxt   = (paid_after != '0) ? S_CHANGE : S_IDLE;
            end else if (paid_r >= cur_price) begin
               st_nxt   = S_VEND;
               vend_nxt = 1'b1;
            end
         end
         S_VEND: begin
            rej_nxt  = coin_valid;
            do_vend  = 1'b1;
            sale_nxt = sale_sum[SALE_W] ? '1 : sale_sum[SALE_W-1:0];
            chg_nxt  = paid_r - cur_price;
            paid_nxt = '0;
            st_nxt   = (paid_r != cur_price) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE: begin
            rej_nxt = coin_valid;
            if (chg_ready) begin
               chg_nxt = chg_r - MONEY_W'(chg_coin);
               if (chg_r == MONEY_W'(chg_coin))
                  st_nxt = S_IDLE;
            end
         end
         S_ADMIN: begin
            rej_nxt    = coin_valid;
            id_nxt     = sel_id;
            do_restock = adm_restock;
            do_price   = adm_price_wr && (adm_price != '0);
            if (!adm_mode)
               st_nxt = S_IDLE;
         end
         default: st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= S_IDLE;
         id_r   <= '0;
         paid_r <= '0;
         chg_r  <= '0;
         sale_r <= '0;
         vend_r <= 1'b0;
         rej_r  <= 1'b0;
      end else begin
         st     <= st_nxt;
         id_r   <= id_nxt;
         paid_r <= paid_nxt;
         chg_r  <= chg_nxt;
         sale_r <= sale_nxt;
         vend_r <= vend_nxt;
         rej_r  <= rej_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            stock[i] <= '0;
            sold[i]  <= '0;
            price[i] <= MONEY_W'(DEF_PRICE);
         end
      end else begin
         if (do_vend) begin
            stock[id_r] <= cur_stock - 1'b1;
            sold[id_r]  <= sold_inc;
         end
         if (do_restock)
            stock[id_r] <= STOCK_W'(MAX_STOCK);
         if (do_price)
            price[id_r] <= adm_price;
      end
   end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised multi-item vending controller, the next-generation core behind the vending top level. It replaces the fixed item set with N_ITEMS slots, each with its own stock, sold count and programmable price. It adds coin-by-coin change dispensing over a valid/ready handshake and admin-mode restock and price programming. All button and coin inputs arrive as single-cycle pulses from the existing debounce and edge-detect stage.

Parameters:
N_ITEMS, 8, number of item slots (2..16)
ID_W, 3, item index width; must satisfy 2^ID_W >= N_ITEMS
STOCK_W, 4, stock and sold-counter width
MAX_STOCK, 15, stock value loaded by restock; must be <= 2^STOCK_W-1
MONEY_W, 7, width of paid, price and change
SALE_W, 10, width of the cumulative sales total
DEF_PRICE, 5, price of every slot after reset (1..2^MONEY_W-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
sel_plus  in  1  pulse: next item
sel_minus  in  1  pulse: previous item
confirm  in  1  pulse: buy the selected item
cancel  in  1  pulse: abort payment and refund
coin_valid  in  1  pulse: coin inserted
coin_val  in  4  coin value; only 1, 2, 5, 10 are legal
adm_mode  in  1  level: admin mode request
adm_restock  in  1  pulse: set the selected item's stock to MAX_STOCK
adm_price_wr  in  1  pulse: write adm_price to the selected item
adm_price  in  MONEY_W  new price
chg_ready  in  1  change hopper accepts a coin
chg_valid  out  1  change coin offered
chg_coin  out  4  value of the offered change coin
state  out  3  0=IDLE 1=PAY 2=VEND 3=CHANGE 4=ADMIN
cur_id  out  ID_W  selected item
cur_stock  out  STOCK_W  stock of cur_id
cur_sold  out  STOCK_W  sold count of cur_id
cur_price  out  MONEY_W  price of cur_id
paid  out  MONEY_W  money inserted in the current transaction
change_left  out  MONEY_W  change still owed
sale_total  out  SALE_W  cumulative revenue
sold_out  out  1  combinational: cur_stock==0
vend_pulse  out  1  one-cycle pulse: item released
coin_reject  out  1  one-cycle pulse: coin refused

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-CHANGE): state=IDLE, cur_id=0, every stock=0, every sold=0, every price=DEF_PRICE, paid=0, change_left=0, sale_total=0. chg_valid, vend_pulse and coin_reject are 0. Any pending change is discarded.
- All outputs are registered except sold_out, chg_valid, chg_coin and the cur_* read-mux.
- Item select is active in IDLE and ADMIN only:
  - sel_plus: cur_id+1, wraps N_ITEMS-1 -> 0.
  - sel_minus: cur_id-1, wraps 0 -> N_ITEMS-1.
  - Both pulses in the same cycle: no change.
- IDLE:
  - adm_mode=1 -> ADMIN; this has priority over confirm.
  - confirm with stock!=0 -> PAY, paid=0.
  - confirm with stock==0 -> stay in IDLE.
  - Coins in IDLE: coin_reject pulses, paid unchanged.
- PAY:
  - Legal coin: paid += coin_val, unless the sum would exceed 2^MONEY_W-1. In that case the coin is rejected with coin_reject.
  - Illegal coin_val: coin_reject.
  - cancel: change_left = paid (after any same-cycle coin is added), paid=0, -> CHANGE. If the resulting change_left is 0, go to IDLE instead.
  - Otherwise, if registered paid >= cur_price -> VEND on the next edge. This gives 1 cycle of latency from the completing coin.
  - sel_plus, sel_minus and adm_mode are ignored.
- VEND (exactly 1 cycle):
  - stock[cur_id] -= 1; sold[cur_id] += 1, saturating at 2^STOCK_W-1.
  - sale_total += cur_price, saturating at 2^SALE_W-1.
  - vend_pulse=1.
  - change_left = paid - cur_price; paid=0.
  - -> CHANGE if change_left != 0, else IDLE.
- CHANGE:
  - chg_valid=1; chg_coin = largest of {10,5,2,1} that is <= change_left.
  - On chg_valid && chg_ready: change_left -= chg_coin.
  - When change_left becomes 0 -> IDLE; chg_valid drops in that same cycle.
  - chg_coin is stable while chg_ready=0.
  - Coins are rejected with coin_reject; all other inputs are ignored.
- ADMIN:
  - adm_restock: stock[cur_id] = MAX_STOCK.
  - adm_price_wr: price[cur_id] = adm_price; an adm_price of 0 is ignored.
  - adm_restock and adm_price_wr in the same cycle are both applied.
  - adm_mode=0 -> IDLE; cur_id is retained.
  - Coins are rejected with coin_reject.
- Priority within a cycle: rst > state-specific actions as listed above.

Test Plan:
- Reset, ADMIN, sel_plus x2, restock, price write 7, exit ADMIN -> cur_id=2, stock=15, price=7, state=IDLE.
- From the above: confirm, coins 5, 5 -> VEND 1 cycle after the second coin; vend_pulse; stock=14, sold=1, sale_total=7; change coins 2 then 1 with chg_ready held high; then IDLE.
- Change handshake with price 1 and paid 10: chg_ready low for 5 cycles -> chg_valid=1, chg_coin=5 held stable; then 5, 2, 2 accepted; change_left goes 9 -> 4 -> 2 -> 0.
- PAY: coins 2, coin_val=3, then cancel in the same cycle as coin 1 -> coin_reject on the 3; refund 3 dispensed as 2 then 1; sale_total unchanged, stock unchanged.
- Sold-out and wrap: stock 0 at id 0, confirm -> stays IDLE, sold_out=1. sel_minus from id 0 -> id N_ITEMS-1. Coins inserted in IDLE -> coin_reject.
- Overflow: price 127, insert 10 x12 then 10 -> 13th coin rejected, paid=120. Assert rst mid-CHANGE -> all counters and state return to their reset values on the next edge.
